// File: rtl/sfx_arbiter_pkg.sv
// Shared definitions for the sound-effect arbiter: FSM states, player select codes
// and the fixed abort wait.
package sfx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_ABORT = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam logic [1:0] SFX_NONE     = 2'd0;
  localparam logic [1:0] SFX_LASER_LO = 2'd1;
  localparam logic [1:0] SFX_LASER_HI = 2'd2;
  localparam logic [1:0] SFX_DEATH    = 2'd3;

  localparam int ABORT_MAX_CYC = 4;
  localparam int ACYC_W        = $clog2(ABORT_MAX_CYC);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sfx_arbiter_if.sv
// Handshake bundle between game-event requesters / SFX player and the arbiter.
interface sfx_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int SEL_W   = 2
);
  logic               tick;
  logic [NUM_REQ-1:0] req;
  logic               player_done;
  logic [SEL_W-1:0]   sfx_sel;
  logic               sfx_abort;
  logic               busy;
  logic [NUM_REQ-1:0] ack;
  logic               timeout;

  modport master (
    output tick, req, player_done,
    input  sfx_sel, sfx_abort, busy, ack, timeout
  );

  modport slave (
    input  tick, req, player_done,
    output sfx_sel, sfx_abort, busy, ack, timeout
  );
endinterface

// File: rtl/sfx_arbiter_prio_enc.sv
// Combinational priority encoder: index of the highest set bit plus a valid flag.
module sfx_arbiter_prio_enc
  import sfx_arbiter_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sfx_arbiter.sv
// Arbitrates the single SFX player among NUM_REQ event requesters with optional
// preemption, a tick watchdog and an inter-effect silent gap.
module sfx_arbiter
  import sfx_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int SEL_W         = 2,
  parameter int PREEMPT       = 1,
  parameter int GAP_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 500
) (
  input logic         clk,
  input logic         clr,
  sfx_arbiter_if.slave bus
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = max3(TIMEOUT_TICKS, GAP_TICKS, 1);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state, state_n;
  logic [NUM_REQ-1:0] pending, pending_n;
  logic [IDX_W-1:0]   cur, cur_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ACYC_W-1:0]  acyc, acyc_n;
  logic [IDX_W-1:0]   hi_idx;
  logic               hi_vld;
  logic [NUM_REQ-1:0] grant_mask, active_mask;
  logic               do_ack, do_timeout;
  logic [SEL_W-1:0]   sel_d;
  logic               abort_d, busy_d;
  logic [NUM_REQ-1:0] ack_d;

  sfx_arbiter_prio_enc #(.N(NUM_REQ), .IDX_W(IDX_W)) u_enc (
    .vec (pending),
    .idx (hi_idx),
    .vld (hi_vld)
  );

  // Next state, pending set and shared tick/abort counters
  always_comb begin
    state_n     = state;
    cur_n       = cur;
    grant_mask  = '0;
    active_mask = '0;
    do_ack      = 1'b0;
    do_timeout  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hi_vld) begin
          state_n     = ST_PLAY;
          cur_n       = hi_idx;
          grant_mask  = NUM_REQ'(1) << hi_idx;
          active_mask = NUM_REQ'(1) << hi_idx;
        end
      end
      ST_PLAY: begin
        active_mask = NUM_REQ'(1) << cur;
        if (bus.player_done) begin
          state_n = ST_GAP;
          do_ack  = 1'b1;
        end else if (PREEMPT != 0 && hi_vld && hi_idx > cur) begin
          state_n = ST_ABORT;
        end else if (TIMEOUT_TICKS != 0 && cnt == CNT_W'(TIMEOUT_TICKS)) begin
          state_n    = ST_ABORT;
          do_timeout = 1'b1;
        end
      end
      ST_ABORT: begin
        active_mask = NUM_REQ'(1) << cur;
        if (bus.player_done || acyc == ACYC_W'(ABORT_MAX_CYC - 1))
          state_n = ST_GAP;
      end
      ST_GAP: begin
        if (cnt == CNT_W'(GAP_TICKS))
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase

    pending_n = (pending & ~grant_mask) | (bus.req & ~active_mask);

    // Counters restart on every state change; tick count saturates when idle-running
    if (state_n != state) begin
      cnt_n  = '0;
      acyc_n = '0;
    end else begin
      cnt_n  = (bus.tick && cnt != CNT_W'(CNT_MAX)) ? cnt + 1'b1 : cnt;
      acyc_n = (state == ST_ABORT) ? acyc + 1'b1 : acyc;
    end
  end

  // Output values derived from the upcoming state so the registered outputs track it
  always_comb begin
    sel_d   = SEL_W'(SFX_NONE);
    abort_d = (state_n == ST_ABORT);
    busy_d  = (state_n != ST_IDLE);
    ack_d   = '0;
    if (state_n == ST_PLAY || state_n == ST_ABORT)
      sel_d = SEL_W'(cur_n) + SEL_W'(1);
    if (do_ack)
      ack_d = NUM_REQ'(1) << cur;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (clr) begin
      state         <= ST_IDLE;
      pending       <= '0;
      cur           <= '0;
      cnt           <= '0;
      acyc          <= '0;
      bus.sfx_sel   <= '0;
      bus.sfx_abort <= 1'b0;
      bus.busy      <= 1'b0;
      bus.ack       <= '0;
      bus.timeout   <= 1'b0;
    end else begin
      state         <= state_n;
      pending       <= pending_n;
      cur           <= cur_n;
      cnt           <= cnt_n;
      acyc          <= acyc_n;
      bus.sfx_sel   <= sel_d;
      bus.sfx_abort <= abort_d;
      bus.busy      <= busy_d;
      bus.ack       <= ack_d;
      bus.timeout   <= do_timeout;
    end
  end

endmodule

// File: tb/tb_sfx_arbiter.sv
// Directed bench for sfx_arbiter: one preempting/short-watchdog instance and one
// non-preempting instance share the same stimulus.
module tb_sfx_arbiter;
  import sfx_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       clr;
  logic       tick;
  logic       done;
  logic [2:0] req;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  sfx_arbiter_if #(.NUM_REQ(3), .SEL_W(2)) bus_a ();
  sfx_arbiter_if #(.NUM_REQ(3), .SEL_W(2)) bus_b ();

  assign bus_a.tick        = tick;
  assign bus_a.req         = req;
  assign bus_a.player_done = done;
  assign bus_b.tick        = tick;
  assign bus_b.req         = req;
  assign bus_b.player_done = done;

  sfx_arbiter #(.NUM_REQ(3), .SEL_W(2), .PREEMPT(1), .GAP_TICKS(2), .TIMEOUT_TICKS(5)) dut_a (
    .clk (clk),
    .clr (clr),
    .bus (bus_a.slave)
  );

  sfx_arbiter #(.NUM_REQ(3), .SEL_W(2), .PREEMPT(0), .GAP_TICKS(2), .TIMEOUT_TICKS(500)) dut_b (
    .clk (clk),
    .clr (clr),
    .bus (bus_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_req(input logic [2:0] r);
    req = r;
    cyc(1);
    req = '0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    cyc(1);
    done = 1'b0;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    cyc(2);
    clr = 1'b0;
  endtask

  initial begin
    clr  = 1'b1;
    tick = 1'b0;
    done = 1'b0;
    req  = '0;

    // Reset state
    do_reset();
    chk("rst_sel",     32'(bus_a.sfx_sel),   32'(SFX_NONE));
    chk("rst_abort",   32'(bus_a.sfx_abort), 0);
    chk("rst_busy",    32'(bus_a.busy),      0);
    chk("rst_ack",     32'(bus_a.ack),       0);
    chk("rst_timeout", 32'(bus_a.timeout),   0);

    // 1: single laser, normal completion, gap of two ticks
    pulse_req(3'b001);
    chk("t1_sel_lat1", 32'(bus_a.sfx_sel), 0);
    cyc(1);
    chk("t1_sel_lat2", 32'(bus_a.sfx_sel), 32'(SFX_LASER_LO));
    chk("t1_busy",     32'(bus_a.busy),    1);
    cyc(27);
    pulse_done();
    chk("t1_ack",      32'(bus_a.ack),     32'h1);
    chk("t1_sel_gap",  32'(bus_a.sfx_sel), 0);
    cyc(1);
    chk("t1_ack_pulse", 32'(bus_a.ack),    0);
    pulse_tick();
    pulse_tick();
    chk("t1_busy_gap", 32'(bus_a.busy),    1);
    cyc(1);
    chk("t1_busy_end", 32'(bus_a.busy),    0);

    // 2: death preempts laser
    do_reset();
    pulse_req(3'b001);
    cyc(4);
    pulse_req(3'b100);
    chk("t2_abort_pre",  32'(bus_a.sfx_abort), 0);
    cyc(1);
    chk("t2_abort",      32'(bus_a.sfx_abort), 1);
    chk("t2_sel_held",   32'(bus_a.sfx_sel),   32'(SFX_LASER_LO));
    pulse_done();
    chk("t2_no_ack",     32'(bus_a.ack),       0);
    chk("t2_sel_gap",    32'(bus_a.sfx_sel),   0);
    chk("t2_abort_off",  32'(bus_a.sfx_abort), 0);
    pulse_tick();
    pulse_tick();
    cyc(1);
    chk("t2_idle",       32'(bus_a.busy),      0);
    cyc(1);
    chk("t2_sel_death",  32'(bus_a.sfx_sel),   32'(SFX_DEATH));
    pulse_done();
    chk("t2_ack_death",  32'(bus_a.ack),       32'h4);

    // 3: same stimulus without preemption
    do_reset();
    pulse_req(3'b001);
    cyc(1);
    chk("t3_sel_laser",  32'(bus_b.sfx_sel),   32'(SFX_LASER_LO));
    cyc(2);
    pulse_req(3'b100);
    cyc(1);
    chk("t3_no_abort",   32'(bus_b.sfx_abort), 0);
    chk("t3_sel_keep",   32'(bus_b.sfx_sel),   32'(SFX_LASER_LO));
    pulse_done();
    chk("t3_ack_laser",  32'(bus_b.ack),       32'h1);
    pulse_tick();
    pulse_tick();
    cyc(2);
    chk("t3_sel_death",  32'(bus_b.sfx_sel),   32'(SFX_DEATH));
    pulse_done();
    chk("t3_ack_death",  32'(bus_b.ack),       32'h4);

    // 4: two simultaneous requests served high-to-low, repeat of playing index ignored
    do_reset();
    pulse_req(3'b011);
    cyc(1);
    chk("t4_sel_hi",     32'(bus_a.sfx_sel),   32'(SFX_LASER_HI));
    pulse_req(3'b010);
    cyc(2);
    pulse_done();
    chk("t4_ack_hi",     32'(bus_a.ack),       32'h2);
    pulse_tick();
    pulse_tick();
    cyc(2);
    chk("t4_sel_lo",     32'(bus_a.sfx_sel),   32'(SFX_LASER_LO));
    pulse_done();
    chk("t4_ack_lo",     32'(bus_a.ack),       32'h1);
    pulse_tick();
    pulse_tick();
    cyc(3);
    chk("t4_busy_end",   32'(bus_a.busy),      0);
    chk("t4_sel_end",    32'(bus_a.sfx_sel),   0);

    // 5: watchdog after five ticks, abort exits after four cycles without done
    do_reset();
    pulse_req(3'b001);
    cyc(1);
    chk("t5_busy",       32'(bus_a.busy),      1);
    repeat (5) pulse_tick();
    chk("t5_to_pre",     32'(bus_a.timeout),   0);
    chk("t5_abort_pre",  32'(bus_a.sfx_abort), 0);
    cyc(1);
    chk("t5_timeout",    32'(bus_a.timeout),   1);
    chk("t5_abort",      32'(bus_a.sfx_abort), 1);
    chk("t5_sel_held",   32'(bus_a.sfx_sel),   32'(SFX_LASER_LO));
    cyc(1);
    chk("t5_to_pulse",   32'(bus_a.timeout),   0);
    chk("t5_abort_hold", 32'(bus_a.sfx_abort), 1);
    cyc(2);
    chk("t5_abort_last", 32'(bus_a.sfx_abort), 1);
    cyc(1);
    chk("t5_abort_exit", 32'(bus_a.sfx_abort), 0);
    chk("t5_sel_gap",    32'(bus_a.sfx_sel),   0);
    chk("t5_busy_gap",   32'(bus_a.busy),      1);
    chk("t5_no_ack",     32'(bus_a.ack),       0);

    // 6: clear mid-play with a death request pending
    do_reset();
    pulse_req(3'b001);
    cyc(1);
    pulse_req(3'b100);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("t6_sel_clr",    32'(bus_a.sfx_sel),   0);
    chk("t6_busy_clr",   32'(bus_a.busy),      0);
    cyc(3);
    chk("t6_sel_after",  32'(bus_a.sfx_sel),   0);
    chk("t6_busy_after", 32'(bus_a.busy),      0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
